// File: rtl/awb_shift_gain_pkg.sv
// awb_pkg: shared widths, constants and divider state type for the AWB shift-gain stage
package awb_pkg;
  localparam int GAIN_W = 16;
  localparam int GAIN_ONE = 256;
  localparam int DIV_NUM = 65280;
  localparam int PIX_W = 8;
  typedef enum logic [1:0] {IDLE, DIV, DONE} div_state_e;
endpackage

// File: rtl/awb_shift_gain_if.sv
// awb_video_if: RGB pixel bus with line/frame valid
//   r/g/b: pixel data, hs: line valid, vs: frame valid
//   master drives the bus, slave receives it
interface awb_video_if import awb_pkg::*; ();
  logic [PIX_W-1:0] r, g, b;
  logic hs, vs;
  modport master(output r, g, b, hs, vs);
  modport slave(input r, g, b, hs, vs);
endinterface

// File: rtl/awb_shift_gain_div.sv
// awb_div_seq: 16-bit restoring divider, one quotient bit per cycle
//   i_clk/i_rst: clock, sync active-high reset
//   start/num/den: launch a division (accepted only when idle)
//   done: one-cycle pulse with quot valid, busy: state != IDLE
module awb_div_seq import awb_pkg::*; (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              start,
  input  logic [GAIN_W-1:0] num,
  input  logic [GAIN_W-1:0] den,
  output logic              done,
  output logic              busy,
  output logic [GAIN_W-1:0] quot
);
  div_state_e state_q;
  logic [GAIN_W-1:0] rem_q, acc_q, den_q;
  logic [4:0] cnt_q;
  logic [GAIN_W:0] trial;
  // Remainder stays below den, so the top bit of the trial flags a negative result.
  assign trial = {rem_q, acc_q[GAIN_W-1]} - {1'b0, den_q};
  assign done = state_q == DONE;
  assign busy = state_q != IDLE;
  assign quot = acc_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      acc_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= DIV;
          acc_q <= num;
          den_q <= den;
          rem_q <= '0;
          cnt_q <= '0;
        end
        DIV: if (cnt_q == 5'd16) state_q <= DONE;
        else begin
          cnt_q <= cnt_q + 5'd1;
          rem_q <= trial[GAIN_W] ? {rem_q[GAIN_W-2:0], acc_q[GAIN_W-1]} : trial[GAIN_W-1:0];
          acc_q <= {acc_q[GAIN_W-2:0], ~trial[GAIN_W]};
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/awb_shift_gain.sv
// awb_shift_gain: per-frame red-channel shift/stretch correction, r' = (r - phase) * 255 / (255 - phase)
//   i_clk/i_rst: clock, sync active-high reset
//   img: input pixel bus, o: corrected pixel bus (3-cycle latency)
//   mv_phase: red offset from the histogram search, clamped to MAX_TH
//   o_gain/o_phase: active Q8.8 gain and phase, o_busy: divider running
module awb_shift_gain import awb_pkg::*; #(
  parameter int MAX_TH = 200,
  parameter int SMOOTH_SH = 2,
  parameter int FRAC = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  awb_video_if.slave         img,
  awb_video_if.master        o,
  input  logic [31:0]        mv_phase,
  output logic [GAIN_W-1:0]  o_gain,
  output logic [PIX_W-1:0]   o_phase,
  output logic               o_busy
);
  logic vs_prev_q, vs_rise, start, commit, div_done;
  logic [7:0] p_clamp, phase_f_q, phase_f_d, phase_pend_q, phase_pend_d, phase_act_q, phase_act_d;
  logic [GAIN_W-1:0] gain_pend_q, gain_pend_d, gain_act_q, gain_act_d, quot, den;
  logic pend_valid_q, pend_valid_d;
  logic signed [9:0] diff, step;
  logic [7:0] sub_q, sub_d, r_q, r_d;
  logic [23:0] mul_q, mul_d, rnd, sc;
  logic [2:0][7:0] g_q, g_d, b_q, b_d;
  logic [2:0] hs_q, hs_d, vs_q, vs_d;
  always_comb begin
    vs_rise = img.vs & ~vs_prev_q;
    p_clamp = ((|mv_phase[31:8]) || (mv_phase[7:0] > 8'(MAX_TH))) ? 8'(MAX_TH) : mv_phase[7:0];
    diff = {2'b0, p_clamp} - {2'b0, phase_f_q};
    step = diff >>> SMOOTH_SH;
    // A frame start during a division is ignored for sampling so the result stays coherent.
    start = vs_rise & ~o_busy;
    phase_f_d = start ? phase_f_q + step[7:0] : phase_f_q;
    den = {8'd0, 8'd255 - phase_f_d};
    commit = vs_rise & pend_valid_q;
    phase_act_d = commit ? phase_pend_q : phase_act_q;
    gain_act_d = commit ? gain_pend_q : gain_act_q;
    phase_pend_d = div_done ? phase_f_q : phase_pend_q;
    gain_pend_d = div_done ? quot : gain_pend_q;
    pend_valid_d = div_done | (pend_valid_q & ~commit);
    sub_d = (img.r > phase_act_q) ? img.r - phase_act_q : '0;
    mul_d = {16'd0, sub_q} * {8'd0, gain_act_q};
    rnd = mul_q + 24'(1 << (FRAC - 1));
    sc = rnd >> FRAC;
    r_d = (|sc[23:8]) ? 8'hFF : sc[7:0];
    g_d = {g_q[1:0], img.g};
    b_d = {b_q[1:0], img.b};
    hs_d = {hs_q[1:0], img.hs};
    vs_d = {vs_q[1:0], img.vs};
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_prev_q <= 1'b0;
      phase_f_q <= '0;
      phase_pend_q <= '0;
      phase_act_q <= '0;
      gain_pend_q <= GAIN_W'(GAIN_ONE);
      gain_act_q <= GAIN_W'(GAIN_ONE);
      pend_valid_q <= 1'b0;
      sub_q <= '0;
      mul_q <= '0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      hs_q <= '0;
      vs_q <= '0;
    end else begin
      vs_prev_q <= img.vs;
      phase_f_q <= phase_f_d;
      phase_pend_q <= phase_pend_d;
      phase_act_q <= phase_act_d;
      gain_pend_q <= gain_pend_d;
      gain_act_q <= gain_act_d;
      pend_valid_q <= pend_valid_d;
      sub_q <= sub_d;
      mul_q <= mul_d;
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end
  awb_div_seq u_div (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .start(start),
    .num(GAIN_W'(DIV_NUM)),
    .den(den),
    .done(div_done),
    .busy(o_busy),
    .quot(quot)
  );
  assign o.r = r_q;
  assign o.g = g_q[2];
  assign o.b = b_q[2];
  assign o.hs = hs_q[2];
  assign o.vs = vs_q[2];
  assign o_gain = gain_act_q;
  assign o_phase = phase_act_q;
endmodule
